// File: rtl/divisor8x4.sv
// divisor8x4: 8-bit by 4-bit unsigned restoring shift-subtract divider.
module divisor8x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic [7:0] DV,
  input  logic [3:0] DR,
  output logic [7:0] Q,
  output logic [3:0] R,
  output logic       done,
  output logic       dz
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SUB, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  a_q, a_d, a_sub;
  logic [7:0]  qr_q, qr_d, qr_sub;
  logic [3:0]  b_q, b_d;
  logic [2:0]  iter_q, iter_d;
  logic [7:0]  q_q, q_d;
  logic [3:0]  r_q, r_d;
  logic        dz_q, dz_d, ge;
  always_comb begin
    ge      = a_q >= {1'b0, b_q};
    a_sub   = ge ? a_q - {1'b0, b_q} : a_q;
    qr_sub  = {qr_q[7:1], ge};
    state_d = state_q;
    a_d     = a_q;
    qr_d    = qr_q;
    b_d     = b_q;
    iter_d  = iter_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: state_d = init ? LOAD : IDLE;
      LOAD: begin
        a_d     = '0;
        qr_d    = DV;
        b_d     = DR;
        iter_d  = '0;
        state_d = (DR == '0) ? DONE : SHIFT;
        if (DR == '0) begin
          q_d  = 8'hFF;
          r_d  = 4'hF;
          dz_d = 1'b1;
        end
      end
      SHIFT: begin
        {a_d, qr_d} = {a_q[3:0], qr_q, 1'b0};
        state_d     = SUB;
      end
      SUB: begin
        a_d     = a_sub;
        qr_d    = qr_sub;
        iter_d  = iter_q + 3'd1;
        state_d = (iter_q == 3'd7) ? DONE : SHIFT;
        // Result captured from the final subtract as the FSM enters DONE
        if (iter_q == 3'd7) begin
          q_d  = qr_sub;
          r_d  = a_sub[3:0];
          dz_d = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      qr_q    <= '0;
      b_q     <= '0;
      iter_q  <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qr_q    <= qr_d;
      b_q     <= b_d;
      iter_q  <= iter_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end
  assign Q    = q_q;
  assign R    = r_q;
  assign dz   = dz_q;
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_divisor8x4.sv
// tb_divisor8x4: randomized and directed checks of divisor8x4 against an arithmetic model.
module tb_divisor8x4;
  logic       clk = 1'b0, rst = 1'b1, init = 1'b0;
  logic [7:0] DV = '0;
  logic [3:0] DR = '0;
  logic [7:0] Q;
  logic [3:0] R;
  logic       done, dz;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  divisor8x4 dut (.clk(clk), .rst(rst), .init(init), .DV(DV), .DR(DR),
                  .Q(Q), .R(R), .done(done), .dz(dz));

  function automatic logic [12:0] ref_div(input logic [7:0] dv, input logic [3:0] dr);
    if (dr == 0) return {1'b1, 8'hFF, 4'hF};
    return {1'b0, 8'(dv / dr), 4'(dv % dr)};
  endfunction

  // Caller is at a falling edge; edge 1 is the one that samples init.
  task automatic do_div(input logic [7:0] dv, input logic [3:0] dr,
                        output logic [7:0] q, output logic [3:0] r, output logic z,
                        output int lat, output int wid);
    DV = dv; DR = dr; init = 1'b1;
    lat = 0; wid = 0; q = 'x; r = 'x; z = 1'bx;
    @(posedge clk);
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (n == 1) init = 1'b0;
      if (n == 2) begin DV = 8'($urandom); DR = 4'($urandom); end
      if (done) begin lat = n; q = Q; r = R; z = dz; wid = 1; end
    end
    if (lat != 0) begin
      @(negedge clk);
      if (done) wid++;
    end
  endtask

  task automatic test_reset;
    #3 rst = 1'b0;
    #4;
    checks++;
    if ({Q, R, done, dz} !== 14'd0) begin
      errors++; $display("FAIL reset_state got Q=%0d R=%0d done=%b dz=%b want all 0", Q, R, done, dz);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", done); end
  endtask

  task automatic test_directed;
    logic [7:0] dvs [6] = '{200, 255, 5, 0, 15, 100};
    logic [3:0] drs [6] = '{7, 1, 7, 9, 15, 10};
    logic [7:0] eq  [6] = '{28, 255, 0, 0, 1, 10};
    logic [3:0] er  [6] = '{4, 0, 5, 0, 0, 0};
    logic [7:0] q; logic [3:0] r; logic z; int lat, wid;
    for (int i = 0; i < 6; i++) begin
      do_div(dvs[i], drs[i], q, r, z, lat, wid);
      checks++;
      if (q !== eq[i] || r !== er[i] || z !== 1'b0 || lat != 18 || wid != 1) begin
        errors++;
        $display("FAIL directed_%0d/%0d got Q=%0d R=%0d dz=%b lat=%0d width=%0d want Q=%0d R=%0d dz=0 lat=18 width=1",
                 dvs[i], drs[i], q, r, z, lat, wid, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [7:0] q; logic [3:0] r; logic z; int lat, wid;
    do_div(77, 0, q, r, z, lat, wid);
    checks++;
    if (q !== 8'hFF || r !== 4'hF || z !== 1'b1 || lat != 2 || wid != 1) begin
      errors++;
      $display("FAIL div_zero got Q=%h R=%h dz=%b lat=%0d width=%0d want Q=ff R=f dz=1 lat=2 width=1", q, r, z, lat, wid);
    end
    do_div(100, 10, q, r, z, lat, wid);
    checks++;
    if (q !== 8'd10 || r !== 4'd0 || z !== 1'b0 || lat != 18) begin
      errors++;
      $display("FAIL after_zero got Q=%0d R=%0d dz=%b lat=%0d want Q=10 R=0 dz=0 lat=18", q, r, z, lat);
    end
  endtask

  task automatic test_busy;
    int pulses = 0, first = 0;
    logic [7:0] q = '0; logic [3:0] r = '0;
    DV = 100; DR = 3; init = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) init = 1'b0;
      if (n == 5) begin init = 1'b1; DV = 9; end
      if (n == 6) init = 1'b0;
      if (done) begin
        pulses++;
        if (first == 0) begin first = n; q = Q; r = R; end
      end
    end
    checks++;
    if (pulses != 1 || first != 18 || q !== 8'd33 || r !== 4'd1) begin
      errors++;
      $display("FAIL busy got pulses=%0d lat=%0d Q=%0d R=%0d want pulses=1 lat=18 Q=33 R=1", pulses, first, q, r);
    end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    logic [7:0] q; logic [3:0] r; logic z; int lat, wid;
    DV = 200; DR = 7; init = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) init = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({Q, R, done, dz} !== 14'd0) begin
      errors++; $display("FAIL async_reset got Q=%0d R=%0d done=%b dz=%b want all 0", Q, R, done, dz);
    end
    init = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL reset_no_done got pulses=%0d want 0", pulses); end
    rst = 1'b1;
    do_div(200, 7, q, r, z, lat, wid);
    checks++;
    if (q !== 8'd28 || r !== 4'd4 || z !== 1'b0 || lat != 18 || wid != 1) begin
      errors++;
      $display("FAIL post_reset got Q=%0d R=%0d dz=%b lat=%0d width=%0d want Q=28 R=4 dz=0 lat=18 width=1", q, r, z, lat, wid);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0, first = 0, last = 0, gap_bad = 0, drained = 0;
    DV = 50; DR = 6; init = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first == 0) first = n;
        else if (n - last != 19) gap_bad++;
        last = n;
        checks++;
        if (Q !== 8'd8 || R !== 4'd2 || dz !== 1'b0) begin
          errors++; $display("FAIL b2b_result got Q=%0d R=%0d dz=%b want Q=8 R=2 dz=0", Q, R, dz);
        end
      end
    end
    init = 1'b0;
    for (int n = 0; n < 25 && drained == 0; n++) begin
      @(negedge clk);
      if (done) drained = 1;
    end
    @(negedge clk);
    checks++;
    if (pulses != 3 || first != 18 || gap_bad != 0 || drained != 1) begin
      errors++;
      $display("FAIL back_to_back got pulses=%0d first=%0d bad_gaps=%0d drained=%0d want 3 18 0 1", pulses, first, gap_bad, drained);
    end
  endtask

  task automatic test_random;
    logic [7:0] q, dv; logic [3:0] r, dr; logic z; int lat, wid;
    logic [12:0] e;
    for (int i = 0; i < 40; i++) begin
      dv = 8'($urandom); dr = 4'($urandom);
      e = ref_div(dv, dr);
      do_div(dv, dr, q, r, z, lat, wid);
      checks++;
      if ({z, q, r} !== e || lat != (dr == 0 ? 2 : 18) || wid != 1) begin
        errors++;
        $display("FAIL random_%0d/%0d got Q=%0d R=%0d dz=%b lat=%0d width=%0d want Q=%0d R=%0d dz=%b",
                 dv, dr, q, r, z, lat, wid, e[11:4], e[3:0], e[12]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [7:0] q; logic [3:0] r; logic z; int lat, wid;
    logic [12:0] e;
    for (int dv = 0; dv < 256; dv++) begin
      for (int dr = 1; dr < 16; dr++) begin
        e = ref_div(8'(dv), 4'(dr));
        do_div(8'(dv), 4'(dr), q, r, z, lat, wid);
        checks++;
        if ({z, q, r} !== e || lat != 18 || wid != 1) begin
          errors++;
          $display("FAIL sweep_%0d/%0d got Q=%0d R=%0d dz=%b lat=%0d width=%0d want Q=%0d R=%0d dz=0 lat=18 width=1",
                   dv, dr, q, r, z, lat, wid, e[11:4], e[3:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_div_zero;
    test_busy;
    test_reset_mid;
    test_back_to_back;
    test_random;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
